// File: rtl/tl_arb_pkg.sv
// Shared types and constants for the two-to-one TileLink-UL arbiter.
package tl_arb_pkg;

    // Source IDs carried on the memory-side A channel
    localparam int unsigned SRC_W = 1;
    localparam logic [SRC_W-1:0] SRC_IF = 1'b0;
    localparam logic [SRC_W-1:0] SRC_MA = 1'b1;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_MA = 1'b1
    } owner_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Source ID presented on mem_bus for a given owner
    function automatic logic [SRC_W-1:0] owner_src(input owner_t own);
        return (own == OWN_MA) ? SRC_MA : SRC_IF;
    endfunction

endpackage

// File: rtl/tilelink.sv
// TileLink-UL channel bundle (A and D channels only).
interface tilelink;
    import tl_arb_pkg::*;

    logic                 a_valid;
    logic                 a_ready;
    logic [2:0]           a_opcode;
    logic [1:0]           a_size;
    logic [SRC_W-1:0]     a_source;
    logic [31:0]          a_address;
    logic [31:0]          a_data;
    logic [3:0]           a_mask;

    logic                 d_valid;
    logic                 d_ready;
    logic [2:0]           d_opcode;
    logic [1:0]           d_size;
    logic [SRC_W-1:0]     d_source;
    logic [31:0]          d_data;
    logic                 d_denied;

    modport master (
        output a_valid, a_opcode, a_size, a_source, a_address, a_data, a_mask, d_ready,
        input  a_ready, d_valid, d_opcode, d_size, d_source, d_data, d_denied
    );

    modport slave (
        input  a_valid, a_opcode, a_size, a_source, a_address, a_data, a_mask, d_ready,
        output a_ready, d_valid, d_opcode, d_size, d_source, d_data, d_denied
    );

endinterface

// File: rtl/tl_arb_pick.sv
// Priority picker: memory-access beats fetch. With TL_ARB_FAIR_EN defined, a
// saturating counter of MA grants taken while IF waited forces an IF grant at
// FAIR_LIMIT.
module tl_arb_pick
    import tl_arb_pkg::*;
#(
    parameter int unsigned FAIR_LIMIT = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   if_elig,
    input  logic   ma_elig,
    input  logic   grant,
    output owner_t win
);

`ifdef TL_ARB_FAIR_EN
    localparam int unsigned CNT_W = (FAIR_LIMIT > 0) ? $clog2(FAIR_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FAIR_LIMIT);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             force_if;

    // Winner selection and counter next-state
    always_comb begin
        force_if = if_elig && ma_elig && (cnt_q == CNT_MAX);
        win      = (ma_elig && !force_if) ? OWN_MA : OWN_IF;
        cnt_d    = cnt_q;
        if (grant) begin
            if (win == OWN_MA && if_elig) begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                // Any IF grant, or an MA grant with IF idle, ends the starvation run
                cnt_d = '0;
            end
        end
    end

    // Fairness counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_ok;

    // Strict MA priority; IF may starve
    always_comb begin
        win       = ma_elig ? OWN_MA : OWN_IF;
        unused_ok = ^{clk, rst_n, grant, if_elig};
    end
`endif

endmodule

// File: rtl/tl_arbiter.sv
// Two-to-one TileLink-UL arbiter (fetch vs. memory-access) with one outstanding
// transaction. Optional fairness: define TL_ARB_FAIR_EN.
module tl_arbiter
    import tl_arb_pkg::*;
#(
    parameter int unsigned FAIR_LIMIT = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   if_request,
    tilelink.slave if_bus,
    input  logic   ma_request,
    tilelink.slave ma_bus,
    tilelink.master mem_bus,
    output logic   busy,
    output logic   err
);

    arb_state_t state_q, state_d;
    owner_t     owner_q, owner_d;
    owner_t     win;
    owner_t     sel;
    logic       err_q, err_d;
    logic       if_elig, ma_elig, any_elig, grant;
    logic       sel_a_valid, sel_d_ready;
    logic       a_valid_o, a_ready_o, d_valid_o, d_ready_o;
    logic       unused_ok;

    assign if_elig  = if_request & if_bus.a_valid;
    assign ma_elig  = ma_request & ma_bus.a_valid;
    assign any_elig = if_elig | ma_elig;
    assign grant    = (state_q == IDLE) & any_elig;

    tl_arb_pick #(
        .FAIR_LIMIT (FAIR_LIMIT)
    ) u_pick (
        .clk     (clk),
        .rst_n   (rst_n),
        .if_elig (if_elig),
        .ma_elig (ma_elig),
        .grant   (grant),
        .win     (win)
    );

    // Upstream a_source is replaced by the owner ID
    assign unused_ok = ^{if_bus.a_source, ma_bus.a_source};

    // A-channel source select: live winner in IDLE, locked owner afterwards
    always_comb begin
        sel         = (state_q == IDLE) ? win : owner_q;
        sel_a_valid = (sel == OWN_MA) ? ma_bus.a_valid : if_bus.a_valid;
        sel_d_ready = (owner_q == OWN_MA) ? ma_bus.d_ready : if_bus.d_ready;

        mem_bus.a_opcode  = (sel == OWN_MA) ? ma_bus.a_opcode  : if_bus.a_opcode;
        mem_bus.a_size    = (sel == OWN_MA) ? ma_bus.a_size    : if_bus.a_size;
        mem_bus.a_address = (sel == OWN_MA) ? ma_bus.a_address : if_bus.a_address;
        mem_bus.a_data    = (sel == OWN_MA) ? ma_bus.a_data    : if_bus.a_data;
        mem_bus.a_mask    = (sel == OWN_MA) ? ma_bus.a_mask    : if_bus.a_mask;
        mem_bus.a_source  = owner_src(sel);
    end

    // FSM next-state and handshake strobes
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        err_d     = err_q;
        a_valid_o = 1'b0;
        a_ready_o = 1'b0;
        d_valid_o = 1'b0;
        d_ready_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_elig) begin
                    a_valid_o = 1'b1;
                    a_ready_o = mem_bus.a_ready;
                    owner_d   = win;
                    state_d   = mem_bus.a_ready ? RESP : REQ;
                end
            end
            REQ: begin
                // Owner locked; a dropped request is ignored until A fires
                a_valid_o = sel_a_valid;
                a_ready_o = mem_bus.a_ready;
                if (sel_a_valid && mem_bus.a_ready) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                d_valid_o = mem_bus.d_valid;
                d_ready_o = sel_d_ready;
                if (mem_bus.d_valid && sel_d_ready) begin
                    state_d = IDLE;
                    if (mem_bus.d_source != owner_src(owner_q)) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Route handshakes to the selected master; all forced low while in reset
    always_comb begin
        mem_bus.a_valid = rst_n & a_valid_o;
        mem_bus.d_ready = rst_n & d_ready_o;
        if_bus.a_ready  = rst_n & a_ready_o & (sel == OWN_IF);
        ma_bus.a_ready  = rst_n & a_ready_o & (sel == OWN_MA);
        if_bus.d_valid  = rst_n & d_valid_o & (owner_q == OWN_IF);
        ma_bus.d_valid  = rst_n & d_valid_o & (owner_q == OWN_MA);

        if_bus.d_opcode = mem_bus.d_opcode;
        if_bus.d_size   = mem_bus.d_size;
        if_bus.d_source = mem_bus.d_source;
        if_bus.d_data   = mem_bus.d_data;
        if_bus.d_denied = mem_bus.d_denied;
        ma_bus.d_opcode = mem_bus.d_opcode;
        ma_bus.d_size   = mem_bus.d_size;
        ma_bus.d_source = mem_bus.d_source;
        ma_bus.d_data   = mem_bus.d_data;
        ma_bus.d_denied = mem_bus.d_denied;
    end

    // State, owner latch and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= OWN_IF;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            err_q   <= err_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign err  = err_q;

endmodule

// File: tb/tb_tl_arbiter.sv
// Directed bench for tl_arbiter: IDLE arbitration vector table plus hand-written
// multi-cycle sequences. Inputs change on negedge; outputs sampled 1ns later.
module tb_tl_arbiter;
    import tl_arb_pkg::*;

    logic clk;
    logic rst_n;
    logic if_request;
    logic ma_request;
    logic busy;
    logic err;

    tilelink if_bus ();
    tilelink ma_bus ();
    tilelink mem_bus ();

    tl_arbiter #(
        .FAIR_LIMIT (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_request (if_request),
        .if_bus     (if_bus),
        .ma_request (ma_request),
        .ma_bus     (ma_bus),
        .mem_bus    (mem_bus),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic ifr, ifv, mar, mav, rdy;
        logic exp_av, exp_src, exp_if_rdy, exp_ma_rdy;
    } vec_t;

    vec_t vecs[9];
    logic exp_grant[6];
    int   busy_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        if_request        = 1'b0;
        ma_request        = 1'b0;
        if_bus.a_valid    = 1'b0;
        if_bus.a_opcode   = 3'd4;
        if_bus.a_size     = 2'd2;
        if_bus.a_source   = '0;
        if_bus.a_address  = 32'h1000_0000;
        if_bus.a_data     = 32'h0;
        if_bus.a_mask     = 4'hf;
        if_bus.d_ready    = 1'b1;
        ma_bus.a_valid    = 1'b0;
        ma_bus.a_opcode   = 3'd0;
        ma_bus.a_size     = 2'd2;
        ma_bus.a_source   = '0;
        ma_bus.a_address  = 32'h2000_0000;
        ma_bus.a_data     = 32'h1234_5678;
        ma_bus.a_mask     = 4'h3;
        ma_bus.d_ready    = 1'b1;
        mem_bus.a_ready   = 1'b0;
        mem_bus.d_valid   = 1'b0;
        mem_bus.d_opcode  = 3'd1;
        mem_bus.d_size    = 2'd2;
        mem_bus.d_source  = '0;
        mem_bus.d_data    = 32'h0;
        mem_bus.d_denied  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //              ifr ifv mar mav rdy  av src ifr mar
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

`ifdef TL_ARB_FAIR_EN
        exp_grant = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
`else
        exp_grant = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif

        // Reset state
        clear_inputs();
        rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_mem_a_valid", mem_bus.a_valid, 0);
        chk("rst_mem_d_ready", mem_bus.d_ready, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // IDLE arbitration table; inputs drop before the edge so state stays IDLE
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if_request       = vecs[i].ifr;
            if_bus.a_valid   = vecs[i].ifv;
            ma_request       = vecs[i].mar;
            ma_bus.a_valid   = vecs[i].mav;
            mem_bus.a_ready  = vecs[i].rdy;
            if_bus.a_address = 32'h1000_0000 + 32'(i);
            ma_bus.a_address = 32'h2000_0000 + 32'(i);
            #1;
            chk($sformatf("vec%0d_a_valid", i), mem_bus.a_valid, vecs[i].exp_av);
            if (vecs[i].exp_av) begin
                chk($sformatf("vec%0d_a_source", i), mem_bus.a_source, vecs[i].exp_src);
                chk($sformatf("vec%0d_a_address", i), mem_bus.a_address,
                    vecs[i].exp_src ? 32'h2000_0000 + 32'(i) : 32'h1000_0000 + 32'(i));
            end
            chk($sformatf("vec%0d_if_a_ready", i), if_bus.a_ready, vecs[i].exp_if_rdy);
            chk($sformatf("vec%0d_ma_a_ready", i), ma_bus.a_ready, vecs[i].exp_ma_rdy);
            chk($sformatf("vec%0d_busy", i), busy, 0);
            #1;
            clear_inputs();
        end

        // MA-only read, D returned on the fourth RESP cycle
        @(negedge clk);
        ma_request       = 1'b1;
        ma_bus.a_valid   = 1'b1;
        ma_bus.a_opcode  = 3'd4;
        ma_bus.a_address = 32'h2000_0040;
        mem_bus.a_ready  = 1'b1;
        #1;
        chk("s1_ma_a_ready", ma_bus.a_ready, 1);
        chk("s1_a_source", mem_bus.a_source, 1);
        chk("s1_a_opcode", mem_bus.a_opcode, 4);
        chk("s1_a_address", mem_bus.a_address, 32'h2000_0040);
        busy_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ma_request       = 1'b0;
            ma_bus.a_valid   = 1'b0;
            mem_bus.d_valid  = (i == 3);
            mem_bus.d_source = 1'b1;
            mem_bus.d_data   = 32'hCAFE_0001;
            #1;
            if (busy) busy_cnt++;
            if (i == 3) begin
                chk("s1_ma_d_valid", ma_bus.d_valid, 1);
                chk("s1_ma_d_data", ma_bus.d_data, 32'hCAFE_0001);
                chk("s1_if_d_valid", if_bus.d_valid, 0);
                chk("s1_mem_d_ready", mem_bus.d_ready, 1);
            end
        end
        chk("s1_busy_cycles", busy_cnt, 4);
        chk("s1_err", err, 0);
        clear_inputs();

        // Simultaneous IF and MA: MA first, IF in the IDLE cycle after D fire
        @(negedge clk);
        if_request      = 1'b1;
        if_bus.a_valid  = 1'b1;
        ma_request      = 1'b1;
        ma_bus.a_valid  = 1'b1;
        mem_bus.a_ready = 1'b1;
        #1;
        chk("s2_first_src", mem_bus.a_source, 1);
        chk("s2_first_ma_rdy", ma_bus.a_ready, 1);
        chk("s2_first_if_rdy", if_bus.a_ready, 0);
        @(negedge clk);
        ma_request     = 1'b0;
        ma_bus.a_valid = 1'b0;
        #1;
        chk("s2_resp_if_rdy", if_bus.a_ready, 0);
        chk("s2_resp_a_valid", mem_bus.a_valid, 0);
        @(negedge clk);
        mem_bus.d_valid  = 1'b1;
        mem_bus.d_source = 1'b1;
        #1;
        chk("s2_dfire_if_rdy", if_bus.a_ready, 0);
        chk("s2_dfire_ma_dv", ma_bus.d_valid, 1);
        @(negedge clk);
        mem_bus.d_valid = 1'b0;
        #1;
        chk("s2_second_busy", busy, 0);
        chk("s2_second_valid", mem_bus.a_valid, 1);
        chk("s2_second_src", mem_bus.a_source, 0);
        chk("s2_second_if_rdy", if_bus.a_ready, 1);
        @(negedge clk);
        if_request       = 1'b0;
        if_bus.a_valid   = 1'b0;
        mem_bus.d_valid  = 1'b1;
        mem_bus.d_source = 1'b0;
        mem_bus.d_data   = 32'h0000_1F1F;
        #1;
        chk("s2_if_d_valid", if_bus.d_valid, 1);
        chk("s2_if_d_data", if_bus.d_data, 32'h0000_1F1F);
        chk("s2_ma_d_valid", ma_bus.d_valid, 0);
        @(negedge clk);
        clear_inputs();
        #1;
        chk("s2_idle", busy, 0);
        chk("s2_err", err, 0);

        // A stalled five cycles with MA locked; IF arrives mid-wait
        @(negedge clk);
        ma_request      = 1'b1;
        ma_bus.a_valid  = 1'b1;
        mem_bus.a_ready = 1'b0;
        #1;
        chk("s3_c1_ma_rdy", ma_bus.a_ready, 0);
        chk("s3_c1_a_valid", mem_bus.a_valid, 1);
        @(negedge clk);
        #1;
        chk("s3_c2_busy", busy, 1);
        @(negedge clk);
        if_request     = 1'b1;
        if_bus.a_valid = 1'b1;
        #1;
        chk("s3_c3_if_rdy", if_bus.a_ready, 0);
        chk("s3_c3_src", mem_bus.a_source, 1);
        chk("s3_c3_busy", busy, 1);
        @(negedge clk);
        ma_request = 1'b0;
        #1;
        chk("s3_c4_src", mem_bus.a_source, 1);
        chk("s3_c4_a_valid", mem_bus.a_valid, 1);
        @(negedge clk);
        #1;
        chk("s3_c5_ma_rdy", ma_bus.a_ready, 0);
        @(negedge clk);
        mem_bus.a_ready = 1'b1;
        #1;
        chk("s3_c6_ma_rdy", ma_bus.a_ready, 1);
        chk("s3_c6_if_rdy", if_bus.a_ready, 0);
        @(negedge clk);
        ma_bus.a_valid  = 1'b0;
        mem_bus.a_ready = 1'b0;
        #1;
        chk("s3_resp_busy", busy, 1);
        chk("s3_resp_a_valid", mem_bus.a_valid, 0);
        @(negedge clk);
        if_request       = 1'b0;
        if_bus.a_valid   = 1'b0;
        mem_bus.d_valid  = 1'b1;
        mem_bus.d_source = 1'b1;
        #1;
        chk("s3_ma_d_valid", ma_bus.d_valid, 1);
        @(negedge clk);
        clear_inputs();
        #1;
        chk("s3_idle", busy, 0);

        // D with wrong source while MA owns: delivered to MA, err sticky
        @(negedge clk);
        ma_request      = 1'b1;
        ma_bus.a_valid  = 1'b1;
        mem_bus.a_ready = 1'b1;
        @(negedge clk);
        ma_request       = 1'b0;
        ma_bus.a_valid   = 1'b0;
        mem_bus.a_ready  = 1'b0;
        mem_bus.d_valid  = 1'b1;
        mem_bus.d_source = 1'b0;
        mem_bus.d_data   = 32'hDEAD_BEEF;
        #1;
        chk("s5_ma_d_valid", ma_bus.d_valid, 1);
        chk("s5_ma_d_data", ma_bus.d_data, 32'hDEAD_BEEF);
        chk("s5_if_d_valid", if_bus.d_valid, 0);
        chk("s5_err_before", err, 0);
        @(negedge clk);
        mem_bus.d_valid = 1'b0;
        #1;
        chk("s5_err_set", err, 1);
        chk("s5_busy", busy, 0);
        repeat (3) @(negedge clk);
        #1;
        chk("s5_err_sticky", err, 1);

        // Reset while in RESP with a response pending
        @(negedge clk);
        ma_request      = 1'b1;
        ma_bus.a_valid  = 1'b1;
        mem_bus.a_ready = 1'b1;
        @(negedge clk);
        if_request       = 1'b1;
        if_bus.a_valid   = 1'b1;
        ma_bus.d_ready   = 1'b0;
        mem_bus.d_valid  = 1'b1;
        mem_bus.d_source = 1'b1;
        #1;
        chk("s6_pre_ma_dv", ma_bus.d_valid, 1);
        chk("s6_pre_busy", busy, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("s6_rst_busy", busy, 0);
        chk("s6_rst_err", err, 0);
        chk("s6_rst_ma_dv", ma_bus.d_valid, 0);
        chk("s6_rst_if_dv", if_bus.d_valid, 0);
        chk("s6_rst_ma_ar", ma_bus.a_ready, 0);
        chk("s6_rst_if_ar", if_bus.a_ready, 0);
        chk("s6_rst_mem_av", mem_bus.a_valid, 0);
        chk("s6_rst_mem_dr", mem_bus.d_ready, 0);
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        if_request      = 1'b1;
        if_bus.a_valid  = 1'b1;
        mem_bus.a_ready = 1'b1;
        #1;
        chk("s6_post_if_rdy", if_bus.a_ready, 1);
        chk("s6_post_src", mem_bus.a_source, 0);
        @(negedge clk);
        if_request       = 1'b0;
        if_bus.a_valid   = 1'b0;
        mem_bus.a_ready  = 1'b0;
        mem_bus.d_valid  = 1'b1;
        mem_bus.d_source = 1'b0;
        #1;
        chk("s6_post_if_dv", if_bus.d_valid, 1);
        chk("s6_post_busy", busy, 1);
        @(negedge clk);
        clear_inputs();
        #1;
        chk("s6_post_idle", busy, 0);
        chk("s6_post_err", err, 0);

        // Both masters continuously eligible: grant sequence
        for (int g = 0; g < 6; g++) begin
            @(negedge clk);
            if_request      = 1'b1;
            if_bus.a_valid  = 1'b1;
            ma_request      = 1'b1;
            ma_bus.a_valid  = 1'b1;
            mem_bus.a_ready = 1'b1;
            mem_bus.d_valid = 1'b0;
            #1;
            chk($sformatf("s4_grant%0d", g), mem_bus.a_source, exp_grant[g]);
            @(negedge clk);
            mem_bus.a_ready  = 1'b0;
            mem_bus.d_valid  = 1'b1;
            mem_bus.d_source = exp_grant[g];
        end
        @(negedge clk);
        clear_inputs();
        #1;
        chk("s4_err", err, 0);
        chk("s4_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
